// File: rtl/axi_b_resp_router_if.sv
// Signal bundle for the B-response router: AW-grant push side, target B channel
// and the per-initiator B channels. The router uses 'slave'; its environment uses 'master'.
interface axi_b_resp_router_if #(
   parameter int PORTS    = 6,
   parameter int ID_WIDTH = 4
);
   localparam int PW = $clog2(PORTS);

   logic                      push_valid;
   logic                      push_ready;
   logic [PW-1:0]             push_port;

   logic [ID_WIDTH-1:0]       s_bid;
   logic [1:0]                s_bresp;
   logic                      s_bvalid;
   logic                      s_bready;

   logic [PORTS*ID_WIDTH-1:0] m_bid;
   logic [PORTS*2-1:0]        m_bresp;
   logic [PORTS-1:0]          m_bvalid;
   logic [PORTS-1:0]          m_bready;

   modport slave (
      input  push_valid, push_port, s_bid, s_bresp, s_bvalid, m_bready,
      output push_ready, s_bready, m_bid, m_bresp, m_bvalid
   );

   modport master (
      output push_valid, push_port, s_bid, s_bresp, s_bvalid, m_bready,
      input  push_ready, s_bready, m_bid, m_bresp, m_bvalid
   );
endinterface

// File: rtl/axi_b_resp_router.sv
// In-order B-response router: remembers the granted initiator for each accepted AW and
// steers the target's B beats back through one registered output stage.
// Optional sticky protocol-error detection: define B_ROUTER_ERR_DETECT_EN.
module axi_b_resp_router #(
   parameter int PORTS    = 6,
   parameter int DEPTH    = 8,
   parameter int ID_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   axi_b_resp_router_if.slave         bus,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       err_unexpected
);
   localparam int PW = $clog2(PORTS);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]       fifo_mem [DEPTH];
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic                fifo_full, fifo_empty;
   logic                push, accept, drain, sel_ready;

   logic                out_valid_q, out_valid_d;
   logic [PW-1:0]       out_port_q, out_port_d;
   logic [ID_WIDTH-1:0] out_bid_q, out_bid_d;
   logic [1:0]          out_bresp_q, out_bresp_d;

   // The extra pointer MSB separates a wrapped-full FIFO from an empty one.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign bus.push_ready = !fifo_full;
   assign push           = bus.push_valid && !fifo_full;

   // A held beat for a non-existent port has no ready to wait for, so it drains at once.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      sel_ready    = 1'b1;
      bus.m_bvalid = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (out_port_q == PW'(i)) begin
            sel_ready       = bus.m_bready[i];
            bus.m_bvalid[i] = out_valid_q;
         end
      end
   end

   assign drain        = out_valid_q && sel_ready;
   assign bus.s_bready = !fifo_empty && (!out_valid_q || drain);
   assign accept       = bus.s_bvalid && bus.s_bready;

   assign bus.m_bid    = {PORTS{out_bid_q}};
   assign bus.m_bresp  = {PORTS{out_bresp_q}};

   assign outstanding  = CW'(wr_ptr_q - rd_ptr_q) + CW'(out_valid_q);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_port_d  = out_port_q;
      out_bid_d   = out_bid_q;
      out_bresp_d = out_bresp_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (accept) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         out_valid_d = 1'b1;
         out_port_d  = fifo_mem[rd_ptr_q[AW-1:0]];
         out_bid_d   = bus.s_bid;
         out_bresp_d = bus.s_bresp;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_port_q  <= '0;
         out_bid_q   <= '0;
         out_bresp_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_port_q  <= out_port_d;
         out_bid_q   <= out_bid_d;
         out_bresp_q <= out_bresp_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= bus.push_port;
      end
   end

`ifdef B_ROUTER_ERR_DETECT_EN
   logic err_q, err_d;
   logic push_port_ok;

   always_comb begin
      push_port_ok = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (bus.push_port == PW'(i)) push_port_ok = 1'b1;
      end
   end

   // Sticky: a B beat with nothing tracked, or a grant for a port that does not exist.
   always_comb begin
      err_d = err_q;
      if ((bus.s_bvalid && fifo_empty && !out_valid_q) || (push && !push_port_ok)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_q <= 1'b0;
      else         err_q <= err_d;
   end

   assign err_unexpected = err_q;
`else
   assign err_unexpected = 1'b0;
`endif

endmodule

// File: tb/tb_axi_b_resp_router.sv
// Self-checking bench for axi_b_resp_router: vector table, directed corner sequences and
// randomized traffic, all compared every cycle against a queue-based reference model.
module tb_axi_b_resp_router;
   localparam int PORTS    = 6;
   localparam int DEPTH    = 8;
   localparam int ID_WIDTH = 4;
   localparam int PW       = $clog2(PORTS);
   localparam int CW       = $clog2(DEPTH+1);
`ifdef B_ROUTER_ERR_DETECT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic [CW-1:0] outstanding;
   logic          err_unexpected;

   int n_checks = 0;
   int n_fail   = 0;

   axi_b_resp_router_if #(.PORTS(PORTS), .ID_WIDTH(ID_WIDTH)) bus ();

   axi_b_resp_router #(.PORTS(PORTS), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .bus            (bus),
      .outstanding    (outstanding),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   // Reference model: queue of granted ports awaiting a B beat, plus the beat being presented.
   int mq[$];
   bit m_hv;
   int m_hp, m_hbid, m_hbr;
   bit m_err;
   int acc_cnt, push_cnt, drain_cnt;

   typedef struct {
      bit               pv;
      int               pp;
      bit               sv;
      int               bid;
      int               br;
      logic [PORTS-1:0] rdy;
      logic [PORTS-1:0] e_mbv;
      int               e_bid;
      int               e_br;
      int               e_out;
      bit               e_pr;
      bit               e_sb;
   } vec_t;

   vec_t vt [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [ID_WIDTH-1:0] bid_of(input int p);
      return bus.m_bid[p*ID_WIDTH +: ID_WIDTH];
   endfunction

   function automatic logic [1:0] bresp_of(input int p);
      return bus.m_bresp[p*2 +: 2];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit pv, input int pp, input bit sv, input int bid, input int br,
                        input logic [PORTS-1:0] rdy);
      bus.push_valid = pv;
      bus.push_port  = PW'(pp);
      bus.s_bvalid   = sv;
      bus.s_bid      = ID_WIDTH'(bid);
      bus.s_bresp    = 2'(br);
      bus.m_bready   = rdy;
   endtask

   task automatic apply(input bit pv, input int pp, input bit sv, input int bid, input int br,
                        input logic [PORTS-1:0] rdy);
      drive(pv, pp, sv, bid, br, rdy);
      #1;
   endtask

   task automatic model_clear();
      mq.delete();
      m_hv = 1'b0; m_hp = 0; m_hbid = 0; m_hbr = 0; m_err = 1'b0;
      acc_cnt = 0; push_cnt = 0; drain_cnt = 0;
   endtask

   // Compares the DUT against the model for the current inputs, advances the model, then clocks.
   task automatic commit();
      int               cnt = mq.size();
      bit               sel_rdy, exp_sb, exp_pr, acc, psh;
      logic [PORTS-1:0] exp_mbv;
      exp_pr  = (cnt < DEPTH);
      sel_rdy = 1'b0;
      exp_mbv = '0;
      if (m_hv) begin
         if (m_hp >= PORTS) sel_rdy = 1'b1;
         else begin
            sel_rdy = bus.m_bready[m_hp];
            exp_mbv[m_hp] = 1'b1;
         end
      end
      exp_sb = (cnt > 0) && (!m_hv || sel_rdy);
      check("model m_bvalid",    64'(bus.m_bvalid),    64'(exp_mbv));
      check("model push_ready",  64'(bus.push_ready),  64'(exp_pr));
      check("model s_bready",    64'(bus.s_bready),    64'(exp_sb));
      check("model outstanding", 64'(outstanding),     64'(cnt + int'(m_hv)));
      check("model err",         64'(err_unexpected),  64'(m_err));
      if (m_hv && m_hp < PORTS) begin
         check("model m_bid",   64'(bid_of(m_hp)),   64'(m_hbid));
         check("model m_bresp", 64'(bresp_of(m_hp)), 64'(m_hbr));
      end
      acc = bus.s_bvalid && exp_sb;
      psh = bus.push_valid && exp_pr;
      if (ERR_EN && ((bus.s_bvalid && cnt == 0 && !m_hv) ||
                     (psh && int'(bus.push_port) >= PORTS))) m_err = 1'b1;
      if (sel_rdy) drain_cnt++;
      if (acc) begin
         m_hp   = mq.pop_front();
         m_hv   = 1'b1;
         m_hbid = int'(bus.s_bid);
         m_hbr  = int'(bus.s_bresp);
         acc_cnt++;
      end else if (sel_rdy) begin
         m_hv = 1'b0;
      end
      if (psh) begin
         mq.push_back(int'(bus.push_port));
         push_cnt++;
      end
      tick();
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, '1);
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_clear();
      tick();
   endtask

   task automatic drain_all(input string name);
      int guard = 0;
      while ((mq.size() > 0 || m_hv) && guard < 40) begin
         apply(0, 0, 1, guard & 15, guard & 3, '1);
         commit();
         guard++;
      end
      apply(0, 0, 0, 0, 0, '1);
      check({name, " outstanding after drain"}, 64'(outstanding), 64'(0));
      commit();
   endtask

   initial begin
      resetn = 1'b0;
      drive(0, 0, 0, 0, 0, '1);
      model_clear();

      //                pv pp sv bid br rdy      e_mbv      bid br out pr sb
      vt[0] = '{1'b0, 0, 1'b0, 0, 0, 6'h3f, 6'b000000, 0, 0, 0, 1'b1, 1'b0};
      vt[1] = '{1'b1, 3, 1'b0, 0, 0, 6'h3f, 6'b000000, 0, 0, 0, 1'b1, 1'b0};
      vt[2] = '{1'b1, 0, 1'b0, 0, 0, 6'h3f, 6'b000000, 0, 0, 1, 1'b1, 1'b1};
      vt[3] = '{1'b1, 5, 1'b0, 0, 0, 6'h3f, 6'b000000, 0, 0, 2, 1'b1, 1'b1};
      vt[4] = '{1'b0, 0, 1'b1, 1, 0, 6'h3f, 6'b000000, 0, 0, 3, 1'b1, 1'b1};
      vt[5] = '{1'b0, 0, 1'b1, 2, 0, 6'h3f, 6'b001000, 1, 0, 3, 1'b1, 1'b1};
      vt[6] = '{1'b0, 0, 1'b1, 3, 0, 6'h3f, 6'b000001, 2, 0, 2, 1'b1, 1'b1};
      vt[7] = '{1'b0, 0, 1'b0, 0, 0, 6'h3f, 6'b100000, 3, 0, 1, 1'b1, 1'b0};
      vt[8] = '{1'b0, 0, 1'b0, 0, 0, 6'h3f, 6'b000000, 0, 0, 0, 1'b1, 1'b0};

      // Reset state and the basic three-port routing sequence.
      do_reset();
      check("reset m_bid",   64'(bus.m_bid),     64'(0));
      check("reset m_bresp", 64'(bus.m_bresp),   64'(0));
      check("reset err",     64'(err_unexpected), 64'(0));
      for (int k = 0; k < 9; k++) begin
         apply(vt[k].pv, vt[k].pp, vt[k].sv, vt[k].bid, vt[k].br, vt[k].rdy);
         check($sformatf("vec%0d m_bvalid", k),    64'(bus.m_bvalid),   64'(vt[k].e_mbv));
         check($sformatf("vec%0d outstanding", k), 64'(outstanding),    64'(vt[k].e_out));
         check($sformatf("vec%0d push_ready", k),  64'(bus.push_ready), 64'(vt[k].e_pr));
         check($sformatf("vec%0d s_bready", k),    64'(bus.s_bready),   64'(vt[k].e_sb));
         for (int p = 0; p < PORTS; p++) begin
            if (vt[k].e_mbv[p]) begin
               check($sformatf("vec%0d m_bid", k),   64'(bid_of(p)),   64'(vt[k].e_bid));
               check($sformatf("vec%0d m_bresp", k), 64'(bresp_of(p)), 64'(vt[k].e_br));
            end
         end
         commit();
      end

      // Fill to full, refused push, then full FIFO with push/accept/drain overlap.
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         apply(1, 2, 0, 0, 0, '1);
         check("fill push_ready", 64'(bus.push_ready), 64'(1));
         commit();
      end
      apply(1, 2, 0, 0, 0, '1);
      check("full push_ready",  64'(bus.push_ready), 64'(0));
      check("full outstanding", 64'(outstanding),    64'(8));
      commit();
      apply(0, 0, 0, 0, 0, '1);
      check("ninth push ignored", 64'(outstanding), 64'(8));
      commit();
      apply(0, 0, 1, 7, 1, '1);
      check("full s_bready", 64'(bus.s_bready), 64'(1));
      commit();
      apply(0, 0, 0, 0, 0, '1);
      check("push_ready after pop", 64'(bus.push_ready), 64'(1));
      check("full drain m_bvalid",  64'(bus.m_bvalid),   64'(6'b000100));
      check("full drain m_bresp",   64'(bresp_of(2)),    64'(1));
      commit();
      apply(0, 0, 1, 8, 0, 6'b111011); commit();
      apply(1, 2, 0, 0, 0, 6'b111011); commit();
      apply(1, 2, 0, 0, 0, 6'b111011); commit();
      apply(1, 5, 1, 9, 0, 6'b111011);
      check("full+held outstanding", 64'(outstanding),    64'(9));
      check("full+held s_bready",    64'(bus.s_bready),   64'(0));
      commit();
      apply(1, 5, 1, 9, 0, '1);
      check("full drain+accept s_bready",   64'(bus.s_bready),   64'(1));
      check("full drain+accept push_ready", 64'(bus.push_ready), 64'(0));
      commit();
      apply(1, 5, 1, 10, 2, '1);
      check("push+accept+drain push_ready", 64'(bus.push_ready), 64'(1));
      check("push+accept+drain s_bready",   64'(bus.s_bready),   64'(1));
      check("push+accept+drain before",     64'(outstanding),    64'(8));
      commit();
      apply(0, 0, 0, 0, 0, 6'b000000);
      check("push+accept+drain after", 64'(outstanding), 64'(8));
      commit();
      drain_all("full");

      // Held beat with back-pressure on port 1 while a second entry waits.
      do_reset();
      apply(1, 1, 0, 0, 0, '1); commit();
      apply(1, 1, 0, 0, 0, '1); commit();
      apply(0, 0, 1, 5, 2, 6'b111101);
      check("hold first accept", 64'(bus.s_bready), 64'(1));
      commit();
      for (int k = 0; k < 4; k++) begin
         apply(0, 0, 1, 6, 0, 6'b111101);
         check("hold m_bvalid", 64'(bus.m_bvalid), 64'(6'b000010));
         check("hold m_bid",    64'(bid_of(1)),    64'(5));
         check("hold m_bresp",  64'(bresp_of(1)),  64'(2));
         check("hold s_bready", 64'(bus.s_bready), 64'(0));
         commit();
      end
      apply(0, 0, 1, 6, 0, '1);
      check("release s_bready", 64'(bus.s_bready), 64'(1));
      commit();
      apply(0, 0, 0, 0, 0, '1);
      check("second beat m_bvalid", 64'(bus.m_bvalid), 64'(6'b000010));
      check("second beat m_bid",    64'(bid_of(1)),    64'(6));
      commit();
      apply(0, 0, 0, 0, 0, '1);
      check("hold idle outstanding", 64'(outstanding), 64'(0));
      commit();

      // Twenty in-order transactions alternating ports 0 and 5 wrap both pointers.
      do_reset();
      begin
         int cyc = 0;
         while (drain_cnt < 20 && cyc < 80) begin
            apply(push_cnt < 20, (push_cnt % 2 == 1) ? 5 : 0,
                  cyc >= 2 && acc_cnt < 20, acc_cnt & 15, acc_cnt & 3, '1);
            commit();
            cyc++;
         end
         check("wrap delivered count", 64'(drain_cnt), 64'(20));
         apply(0, 0, 0, 0, 0, '1);
         check("wrap outstanding", 64'(outstanding), 64'(0));
         commit();
      end

      // Asynchronous reset with three entries outstanding and port 4 presenting a beat.
      do_reset();
      apply(1, 4, 0, 0, 0, '1); commit();
      apply(1, 4, 0, 0, 0, '1); commit();
      apply(1, 1, 0, 0, 0, '1); commit();
      apply(0, 0, 1, 3, 0, 6'b101111); commit();
      apply(0, 0, 0, 0, 0, 6'b101111);
      check("pre-reset m_bvalid",    64'(bus.m_bvalid), 64'(6'b010000));
      check("pre-reset outstanding", 64'(outstanding),  64'(3));
      resetn = 1'b0;
      #1;
      check("async reset m_bvalid",    64'(bus.m_bvalid), 64'(0));
      check("async reset outstanding", 64'(outstanding),  64'(0));
      check("async reset s_bready",    64'(bus.s_bready), 64'(0));
      model_clear();
      drive(0, 0, 0, 0, 0, '1);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      apply(1, 4, 0, 0, 0, '1); commit();
      apply(0, 0, 1, 9, 1, '1); commit();
      apply(0, 0, 0, 0, 0, '1);
      check("post-reset m_bvalid", 64'(bus.m_bvalid), 64'(6'b010000));
      check("post-reset m_bid",    64'(bid_of(4)),    64'(9));
      commit();

      // Unexpected B beat with nothing tracked.
      do_reset();
      apply(0, 0, 1, 1, 0, '1);
      check("err before", 64'(err_unexpected), 64'(0));
      commit();
      for (int k = 0; k < 4; k++) begin
         apply(0, 0, 0, 0, 0, '1);
         check("err sticky", 64'(err_unexpected), 64'(ERR_EN));
         commit();
      end
      do_reset();
      check("err cleared by reset", 64'(err_unexpected), 64'(0));

      // Grant for a non-existent port: stored, drives nothing, drains by itself.
      apply(1, 7, 0, 0, 0, '1); commit();
      apply(0, 0, 1, 4, 0, 6'b000000); commit();
      apply(0, 0, 0, 0, 0, 6'b000000);
      check("bad port m_bvalid",    64'(bus.m_bvalid),   64'(0));
      check("bad port outstanding", 64'(outstanding),    64'(1));
      check("bad port err",         64'(err_unexpected), 64'(ERR_EN));
      commit();
      apply(0, 0, 0, 0, 0, 6'b000000);
      check("bad port self-drain", 64'(outstanding), 64'(0));
      commit();

      // Randomized traffic against the model, then a full drain.
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         logic [PORTS-1:0] rdy;
         int               pp;
         for (int p = 0; p < PORTS; p++) rdy[p] = ($urandom_range(0, 3) != 0);
         pp = ($urandom_range(0, 19) == 0) ? int'($urandom_range(PORTS, (1 << PW) - 1))
                                           : int'($urandom_range(0, PORTS - 1));
         apply($urandom_range(0, 1) == 1, pp, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, (1 << ID_WIDTH) - 1)), int'($urandom_range(0, 3)), rdy);
         commit();
      end
      drain_all("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_b_resp_router.md
Name: axi_b_resp_router

Overview:
- Return-path companion to the interconnect's request arbiter.
- Records, in issue order, which initiator port won each write-address grant.
- Steers the single target's write responses (B channel) back to that initiator.
- Sits between the arbiter/AW mux and the PORTS initiator-side B channels; uses an in-order ordering FIFO plus one registered output stage.

Parameters:
- PORTS, 6, number of initiator ports (2..16).
- DEPTH, 8, maximum outstanding writes tracked; power of 2, >=2.
- ID_WIDTH, 4, width of BID passed through unchanged.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- push_valid  input  1  AW accepted toward target this cycle; record push_port.
- push_ready  output  1  ordering FIFO can accept an entry.
- push_port  input  $clog2(PORTS)  grant_encoded of the initiator whose AW was accepted.
- s_bid  input  ID_WIDTH  target BID.
- s_bresp  input  2  target BRESP.
- s_bvalid  input  1  target B valid.
- s_bready  output  1  router accepts target B beat.
- m_bid  output  PORTS*ID_WIDTH  per-port BID, port i at [i*ID_WIDTH +: ID_WIDTH].
- m_bresp  output  PORTS*2  per-port BRESP.
- m_bvalid  output  PORTS  per-port B valid; at most one bit set.
- m_bready  input  PORTS  per-port B ready.
- outstanding  output  $clog2(DEPTH+1)  entries in FIFO plus 1 if output stage holds a beat.
- err_unexpected  output  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset (resetn low, async): FIFO pointers 0, output stage empty, m_bvalid=0, m_bid=0, m_bresp=0, s_bready=0, outstanding=0, err_unexpected=0; push_ready=1 after reset releases.
- FIFO: DEPTH entries of $clog2(PORTS) bits; pointers are $clog2(DEPTH)+1 bits wide, so wrap is full/empty disambiguated by the MSB.
  - push_ready = !full; it ignores a same-cycle pop.
  - A push occurs when push_valid && push_ready.
  - push_valid while full: no write, no state change; the upstream holds AW.
- Output stage: one register holding {port, bid, bresp, valid}.
  - drain = out_valid && m_bready[out_port].
  - s_bready = !fifo_empty && (!out_valid || drain); registered FIFO empty is used, so there is no push-to-pop bypass.
  - Beat accepted (s_bvalid && s_bready): output stage loads {FIFO head, s_bid, s_bresp}, FIFO pops, out_valid=1.
  - Latency: target beat accepted at cycle N gives m_bvalid[port] high from cycle N+1. Back-to-back beats sustain 1 per cycle when the destination keeps m_bready high.
  - m_bvalid[i] = out_valid && out_port==i. m_bid/m_bresp are driven on every port slice from the output register; only the valid bit is decoded.
  - Drain without a new accept clears out_valid. Drain plus accept in the same cycle reloads with no bubble.
  - Held beat: BID/BRESP/port stay stable until drained (AXI valid-stability).
- Simultaneous push and pop: both take effect; count unchanged.
  - Push into an empty FIFO: the entry becomes poppable the next cycle.
  - Pop of the last entry plus push in the same cycle: FIFO remains non-empty.
- outstanding: updates the cycle after each push/accept/drain event; width saturates naturally at DEPTH+1.
- push_port >= PORTS: stored as-is. The resulting beat drives no m_bvalid bit and drains on its own the next cycle (treated as always-ready), so the pipe never stalls.
- Reset mid-operation: all in-flight entries and any held beat are discarded immediately; no m_bvalid glitch after resetn asserts.

Optional Feature:
- Macro: B_ROUTER_ERR_DETECT_EN.
- Defined: err_unexpected sets (sticky until reset) on any cycle where:
  - s_bvalid=1 && fifo_empty && !out_valid, or
  - a push has push_port >= PORTS.
- Undefined: err_unexpected tied 0; no detection logic synthesised. Port list is identical either way.

Test Plan:
- Reset, then push ports 3,0,5 on cycles 1-3; target returns BID 1,2,3 with BRESP OKAY, m_bready all 1 -> m_bvalid = 6'b001000, 6'b000001, 6'b100000 on consecutive cycles starting 1 cycle after first accept, with BIDs 1,2,3; outstanding returns to 0.
- Push 8 entries (port 2) without responses -> push_ready=0 and outstanding=8 after the 8th push; a 9th push_valid is ignored; one B accept and drain -> push_ready=1 next cycle.
- Push port 1, target B valid, m_bready[1]=0 for 4 cycles -> m_bvalid[1] held with stable BID/BRESP; s_bready=0 while a second entry is pending; release m_bready -> both beats delivered back-to-back.
- FIFO full with out_valid draining, push and accept in the same cycle -> outstanding unchanged, no entry lost; pointer wrap exercised over 20 transactions alternating ports 0 and 5, all delivered in order.
- Assert resetn low while 3 entries are outstanding and m_bvalid[4] is high -> m_bvalid=0 and outstanding=0 immediately; after release a new push/response to port 4 works normally.
- With B_ROUTER_ERR_DETECT_EN, s_bvalid=1 while nothing is outstanding -> err_unexpected=1 next cycle, staying 1 until reset. Without the macro -> err_unexpected stays 0.
